// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with an N-cycle shift-add multiplier.
// One operation is in flight at a time. Operands are captured on acceptance.
// The result and the zero flag are registered. They are held through
// backpressure and remain visible in IDLE until the next operation completes.
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   func,
  input  logic         mul,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] result,
  output logic         ZF,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;      // operand A; in MUL it is the shifting multiplicand
  logic [N-1:0]   b_q, b_d;      // operand B; in MUL it is the shifting multiplier
  logic [2:0]     func_q, func_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   res_q, res_d;
  logic           zf_q, zf_d;

  // Single-cycle ALU operation. All arithmetic is taken modulo 2^N.
  function automatic logic [N-1:0] alu_op(input logic [2:0] f,
                                          input logic [N-1:0] x,
                                          input logic [N-1:0] y);
    logic [N-1:0] r;
    case (f)
      3'd0:    r = x;
      3'd1:    r = y;
      3'd2:    r = x + y;
      3'd3:    r = x - y;
      3'd4:    r = x & y;
      3'd5:    r = x | y;
      3'd6:    r = x ^ y;
      default: r = ~(x | y);
    endcase
    return r;
  endfunction

  // State and datapath registers. Reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zf_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zf_q    <= zf_d;
    end
  end

  // Next-state logic, operand capture, ALU evaluation and shift-add step.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    func_d  = func_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zf_d    = zf_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = a;
          b_d     = b;
          func_d  = func;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = mul ? MUL : EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_op(func_q, a_q, b_q);
        zf_d    = (res_d == '0);
        state_d = DONE;
      end
      MUL: begin
        // Consume one multiplier bit per cycle, LSB first. Product bits
        // above N are dropped.
        acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          res_d   = acc_d;
          zf_d    = (acc_d == '0);
          state_d = DONE;
        end
      end
      default: begin
        if (rsp_ready) state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign result    = res_q;
  assign ZF        = zf_q;

endmodule
